// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks (adder/subtractor)
// that hang off the common start/done arithmetic controller.
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

  // Bit counter width: one extra bit beyond $clog2 so WIDTH itself is representable.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set on underflow of that bit.
module serial_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH clocks with one borrow FF,
// parallel operand capture on start and a one-cycle done pulse with held results.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] d_sh_next;

  serial_full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The current result bit enters at the MSB so that after WIDTH steps bit 0 sits at LSB.
  assign d_sh_next = {cell_d, d_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            d_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_sh_next;
          br   <= cell_bout;
          cnt  <= cnt + 1'b1;
          // Final bit: publish the parallel result and drop back so start can be taken next cycle.
          if (cnt == LAST_BIT) begin
            diff   <= d_sh_next;
            borrow <= cell_bout;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=4) with multi-cycle corner sequences.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs [8];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; issues a one-cycle start and checks the full transaction.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] ed,
                        input logic eb, input string nm);
    logic [3:0] hd;
    logic       hb;
    int         lat;
    bit         got;
    hd = diff;
    hb = borrow;
    start = 1'b1;
    a = ta;
    b = tb_;
    tick();
    start = 1'b0;
    chk({nm, "_busy_on_accept"}, int'(busy), 1);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= WIDTH + 2 && !got; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        lat = i;
      end else if (diff != hd || borrow != hb) begin
        chk({nm, "_hold_diff"}, int'(diff), int'(hd));
        chk({nm, "_hold_borrow"}, int'(borrow), int'(hb));
      end
    end
    if (!got) begin
      chk({nm, "_done_timeout"}, 0, 1);
    end else begin
      chk({nm, "_latency"}, lat, WIDTH);
      chk({nm, "_diff"}, int'(diff), int'(ed));
      chk({nm, "_borrow"}, int'(borrow), int'(eb));
      chk({nm, "_busy_in_done"}, int'(busy), 0);
      tick();
      chk({nm, "_done_pulse_1cyc"}, int'(done), 0);
      chk({nm, "_diff_held"}, int'(diff), int'(ed));
    end
  endtask

  initial begin
    int ndone;
    int d4;
    bit got;

    vecs[0] = '{4'd9,  4'd5,  4'd4,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  4'd14, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  4'd0,  1'b0};
    vecs[3] = '{4'd15, 4'd15, 4'd0,  1'b0};
    vecs[4] = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[5] = '{4'd12, 4'd3,  4'd9,  1'b0};
    vecs[6] = '{4'd8,  4'd7,  4'd1,  1'b0};
    vecs[7] = '{4'd7,  4'd8,  4'd15, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_diff", int'(diff), 0);
    chk("reset_borrow", int'(borrow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));
    end

    // Start re-pulsed mid-run must be ignored.
    start = 1'b1; a = 4'd9; b = 4'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 4'd1; b = 4'd2;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) begin
        ndone++;
        chk("midrun_diff", int'(diff), 4);
        chk("midrun_borrow", int'(borrow), 0);
      end
    end
    chk("midrun_done_count", ndone, 1);

    // Start held high: repeated results, busy drops only in done cycles.
    start = 1'b1; a = 4'd7; b = 4'd2;
    tick();
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("held_busy_vs_done", int'(busy), int'(!done));
      if (done) begin
        ndone++;
        chk("held_diff", int'(diff), 5);
        chk("held_borrow", int'(borrow), 0);
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 3);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (!busy && !done) got = 1'b1;
    end
    chk("held_drain", int'(got), 1);

    // Reset mid-operation aborts with no done and zeroed outputs.
    start = 1'b1; a = 4'd12; b = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_borrow", int'(borrow), 0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(4'd12, 4'd3, 4'd9, 1'b0, "after_abort");

    // All operand pairs against the arithmetic reference.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        d4 = (x - y) & 15;
        run_op(4'(x), 4'(y), 4'(d4), (x < y), $sformatf("ex_%0d_%0d", x, y));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
